// File: rtl/oam_dma_controller.sv
// Sprite OAM DMA engine: passes CPU cycles through, or stalls the CPU and copies a 256-byte page to $2004.
// Optional abort input is compiled in when OAM_DMA_ABORT_EN is defined.
module oam_dma_controller #(
  parameter logic [15:0] TRIG_ADDR    = 16'h4014,
  parameter logic [15:0] OAM_REG_ADDR = 16'h2004,
  parameter int          XFER_LEN     = 256
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_cpu_ce,
  input  logic [15:0] i_cpu_addr,
  input  logic        i_cpu_rnw,
  input  logic [7:0]  i_cpu_data_out,
  input  logic [7:0]  i_bus_data_in,
`ifdef OAM_DMA_ABORT_EN
  input  logic        i_dma_abort,
`endif
  output logic [15:0] o_bus_addr,
  output logic        o_bus_rnw,
  output logic [7:0]  o_bus_data_out,
  output logic        o_cpu_rdy,
  output logic        o_dma_active
);

  typedef enum logic [2:0] {IDLE, HALT, ALIGN, READ, WRITE} state_t;

  state_t      state, next_state;
  logic        parity;
  logic [7:0]  page;
  logic [8:0]  idx;
  logic [7:0]  latch;
  logic        abort_req;
  logic        trigger;
  logic        last_byte;

`ifdef OAM_DMA_ABORT_EN
  assign abort_req = i_dma_abort;
`else
  assign abort_req = 1'b0;
`endif

  assign trigger   = !i_cpu_rnw && (i_cpu_addr == TRIG_ADDR);
  assign last_byte = (idx == 9'(XFER_LEN - 1));

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      parity <= 1'b0;
      page   <= 8'h00;
      idx    <= 9'd0;
      latch  <= 8'h00;
    end else if (i_cpu_ce) begin
      parity <= ~parity;
      state  <= next_state;
      case (state)
        IDLE:  if (trigger) page <= i_cpu_data_out;
        READ:  latch <= i_bus_data_in;
        WRITE: idx <= last_byte ? 9'd0 : idx + 9'd1;
        default: ;
      endcase
      // An abort leaves the counter clean so the next transfer starts at byte 0.
      if (abort_req && state != IDLE) idx <= 9'd0;
    end
  end

  // HALT falls through to READ only when the following cycle is a "get" cycle.
  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (trigger) next_state = HALT;
      HALT:    next_state = abort_req ? IDLE : (parity ? READ : ALIGN);
      ALIGN:   next_state = abort_req ? IDLE : READ;
      READ:    next_state = abort_req ? IDLE : WRITE;
      WRITE:   next_state = (abort_req || last_byte) ? IDLE : READ;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    o_bus_addr     = i_cpu_addr;
    o_bus_rnw      = i_cpu_rnw;
    o_bus_data_out = i_cpu_data_out;
    o_cpu_rdy      = 1'b1;
    o_dma_active   = 1'b0;
    case (state)
      HALT, ALIGN: begin
        o_bus_rnw    = 1'b1;
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
      end
      READ: begin
        o_bus_addr   = {page, idx[7:0]};
        o_bus_rnw    = 1'b1;
        o_cpu_rdy    = 1'b0;
        o_dma_active = 1'b1;
      end
      WRITE: begin
        o_bus_addr     = OAM_REG_ADDR;
        o_bus_rnw      = 1'b0;
        o_bus_data_out = latch;
        o_cpu_rdy      = 1'b0;
        o_dma_active   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_oam_dma_controller.sv
// Directed self-checking bench for oam_dma_controller; memory returns addr[7:0] ^ (page - 2).
// Abort scenario is exercised when OAM_DMA_ABORT_EN is defined.
module tb_oam_dma_controller;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        cpu_ce;
  logic [15:0] cpu_addr;
  logic        cpu_rnw;
  logic [7:0]  cpu_data;
  logic [7:0]  bus_data_in;
  logic [15:0] bus_addr;
  logic        bus_rnw;
  logic [7:0]  bus_data_out;
  logic        cpu_rdy;
  logic        dma_active;
  logic        dma_abort;

  int checks = 0;
  int errors = 0;
  bit par = 1'b0;

  always #5 clk = ~clk;

  // Page $02 returns n at $02nn; other pages are scrambled so a wrong page shows up.
  assign bus_data_in = bus_addr[7:0] ^ (bus_addr[15:8] - 8'h02);

  oam_dma_controller dut (
    .i_clk          (clk),
    .i_rst_n        (rst_n),
    .i_cpu_ce       (cpu_ce),
    .i_cpu_addr     (cpu_addr),
    .i_cpu_rnw      (cpu_rnw),
    .i_cpu_data_out (cpu_data),
    .i_bus_data_in  (bus_data_in),
`ifdef OAM_DMA_ABORT_EN
    .i_dma_abort    (dma_abort),
`endif
    .o_bus_addr     (bus_addr),
    .o_bus_rnw      (bus_rnw),
    .o_bus_data_out (bus_data_out),
    .o_cpu_rdy      (cpu_rdy),
    .o_dma_active   (dma_active)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic ce, input logic [15:0] addr, input logic rnw, input logic [7:0] data);
    cpu_ce   = ce;
    cpu_addr = addr;
    cpu_rnw  = rnw;
    cpu_data = data;
    #1;
  endtask

  task automatic nextCycle();
    @(posedge clk);
    if (cpu_ce) par = ~par;
    #1;
  endtask

  task automatic alignParity(input bit want);
    if (par != want) begin
      applyStimulus(1'b1, 16'h0123, 1'b1, 8'h00);
      nextCycle();
    end
  endtask

  // Triggers a transfer and follows it byte by byte; stop_at >= 0 returns early
  // in the WRITE cycle that completes that many bytes.
  task automatic runDma(input logic [7:0] pg, input int exp_stall, input int freeze_at, input int stop_at);
    int stall = 0;
    int writes = 0;
    bit done = 1'b0;
    bit first_read = 1'b0;
    bit froze = 1'b0;
    logic [7:0] wb;
    applyStimulus(1'b1, 16'h4014, 1'b0, pg);
    checkOutput("trig_addr", bus_addr, 16'h4014);
    checkOutput("trig_rnw", bus_rnw, 0);
    checkOutput("trig_data", bus_data_out, pg);
    checkOutput("trig_rdy", cpu_rdy, 1);
    nextCycle();
    for (int cyc = 0; cyc < 700 && !done; cyc++) begin
      if (freeze_at > 0 && writes == freeze_at && !froze) begin
        froze = 1'b1;
        wb = freeze_at[7:0];
        for (int k = 0; k < 5; k++) begin
          applyStimulus(1'b0, 16'h0300, 1'b0, 8'h55);
          checkOutput("frz_addr", bus_addr, {pg, wb});
          checkOutput("frz_rnw", bus_rnw, 1);
          checkOutput("frz_rdy", cpu_rdy, 0);
          nextCycle();
        end
      end
      applyStimulus(1'b1, 16'h0300, 1'b0, 8'h55);
      if (cpu_rdy) begin
        done = 1'b1;
      end else begin
        stall++;
        checkOutput("active", dma_active, 1);
        if (stall == 1) begin
          checkOutput("halt_addr", bus_addr, 16'h0300);
          checkOutput("halt_rnw", bus_rnw, 1);
        end
        if (!bus_rnw) begin
          wb = writes[7:0];
          checkOutput("waddr", bus_addr, 16'h2004);
          checkOutput("wdata", bus_data_out, wb ^ (pg - 8'h02));
          writes++;
          if (stop_at >= 0 && writes == stop_at) return;
        end else if (bus_addr != 16'h0300) begin
          wb = writes[7:0];
          checkOutput("raddr", bus_addr, {pg, wb});
          if (!first_read) begin
            first_read = 1'b1;
            checkOutput("first_read_par", par, 0);
          end
        end
        nextCycle();
      end
    end
    if (done) begin
      checkOutput("stall_cycles", stall, exp_stall);
      checkOutput("write_count", writes, 256);
      checkOutput("end_active", dma_active, 0);
      checkOutput("end_passthru", bus_addr, 16'h0300);
      nextCycle();
    end else begin
      checkOutput("timeout", 0, 1);
    end
  endtask

  initial begin
    rst_n = 1'b0;
    dma_abort = 1'b0;
    applyStimulus(1'b0, 16'h0000, 1'b1, 8'h00);
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rdy", cpu_rdy, 1);
    checkOutput("rst_active", dma_active, 0);
    rst_n = 1'b1;
    par = 1'b0;

    $display("[TB] idle pass-through");
    applyStimulus(1'b1, 16'h0123, 1'b1, 8'h00);
    checkOutput("idle_addr", bus_addr, 16'h0123);
    checkOutput("idle_rnw", bus_rnw, 1);
    checkOutput("idle_rdy", cpu_rdy, 1);
    checkOutput("idle_active", dma_active, 0);
    nextCycle();

    $display("[TB] even-parity trigger, page 02");
    alignParity(1'b0);
    runDma(8'h02, 513, -1, -1);

    $display("[TB] odd-parity trigger, page 02");
    alignParity(1'b1);
    runDma(8'h02, 514, -1, -1);

    $display("[TB] page FF with cpu_ce freeze");
    alignParity(1'b0);
    runDma(8'hFF, 513, 37, -1);

    $display("[TB] reset during byte 100");
    alignParity(1'b0);
    runDma(8'h40, 513, -1, 100);
    nextCycle();
    #2 rst_n = 1'b0;
    #1;
    checkOutput("async_rdy", cpu_rdy, 1);
    checkOutput("async_active", dma_active, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    par = 1'b0;
    runDma(8'h02, 513, -1, -1);

`ifdef OAM_DMA_ABORT_EN
    $display("[TB] abort during write of byte 10");
    alignParity(1'b0);
    runDma(8'h02, 513, -1, 10);
    nextCycle();
    applyStimulus(1'b1, 16'h0300, 1'b0, 8'h55);
    checkOutput("abort_raddr", bus_addr, 16'h020A);
    nextCycle();
    dma_abort = 1'b1;
    applyStimulus(1'b1, 16'h0300, 1'b0, 8'h55);
    checkOutput("abort_waddr", bus_addr, 16'h2004);
    checkOutput("abort_wdata", bus_data_out, 8'h0A);
    nextCycle();
    dma_abort = 1'b0;
    applyStimulus(1'b1, 16'h0300, 1'b0, 8'h55);
    checkOutput("abort_rdy", cpu_rdy, 1);
    checkOutput("abort_active", dma_active, 0);
    nextCycle();
    alignParity(1'b0);
    runDma(8'h02, 513, -1, -1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
